tt_um_emern_frame_commit: RTL and testbench

- Double-buffered configuration scheduler between the SPI frontend and the pixel core.
- Accepts register writes into a shadow bank at any time.
- When software requests a commit, waits for the next vertical-blank start and copies the shadow bank into the active bank, one register per cycle. The pixel core therefore never sees a half-updated polygon set mid-frame.
- Also keeps a frame counter and a one-cycle completion pulse that feeds the host interrupt pin.

---
 rtl/tt_um_emern_frame_commit.sv | 139 +++++++++++++
 tb/tb_tt_um_emern_frame_commit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_um_emern_frame_commit.sv
// Double-buffered configuration scheduler: shadow writes at any time,
// shadow->active copy one register per cycle starting at vblank rise.
module tt_um_emern_frame_commit #(
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [DATA_W-1:0]            wr_data,
  input  logic                         commit_req,
  input  logic                         vblank,
  output logic [NUM_REGS*DATA_W-1:0]   active_regs,
  output logic                         commit_pending,
  output logic                         commit_done,
  output logic [7:0]                   frame_cnt,
  output logic [1:0]                   err,
  input  logic                         err_clr
);

  localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    COPY  = 2'd2
  } state_t;

  state_t                       r_state;
  state_t                       w_next;
  logic [IDX_W-1:0]             r_idx;
  logic                         r_pend;
  logic                         r_vblank_q;
  logic                         r_done;
  logic [7:0]                   r_frame;
  logic [1:0]                   r_err;
  logic [DATA_W-1:0]            r_shadow [NUM_REGS];
  logic [NUM_REGS*DATA_W-1:0]   r_active;

  logic w_vb_rise;
  logic w_vb_fall;
  logic w_copy;
  logic w_last;
  logic w_wr_acc;
  logic w_addr_ok;

  assign w_vb_rise = vblank & ~r_vblank_q;
  assign w_vb_fall = ~vblank & r_vblank_q;
  assign w_copy    = (r_state == COPY);
  assign w_last    = w_copy && (r_idx == IDX_W'(NUM_REGS - 1));
  assign w_wr_acc  = wr_valid & ~w_copy;
  assign w_addr_ok = (32'(wr_addr) < NUM_REGS);

  assign wr_ready       = ~w_copy;
  assign commit_pending = (r_state != IDLE) | r_pend;
  assign commit_done    = r_done;
  assign frame_cnt      = r_frame;
  assign err            = r_err;
  assign active_regs    = r_active;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state: a commit_req on the final copy cycle also re-arms
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (commit_req) w_next = ARMED;
      ARMED:   if (w_vb_rise)  w_next = COPY;
      COPY:    if (w_last)     w_next = (r_pend | commit_req) ? ARMED : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Copy index, pending-next flag and completion pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx  <= '0;
      r_pend <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_copy && !w_last) r_idx <= r_idx + IDX_W'(1);
      else                   r_idx <= '0;
      if (w_last)                  r_pend <= 1'b0;
      else if (w_copy && commit_req) r_pend <= 1'b1;
    end
  end

  // vblank edge history and frame counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vblank_q <= 1'b1;
      r_frame    <= 8'd0;
    end else begin
      r_vblank_q <= vblank;
      if (w_vb_rise) r_frame <= r_frame + 8'd1;
    end
  end

  // Sticky error flags; a set event beats a simultaneous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 2'b00;
    end else begin
      r_err[0] <= (w_wr_acc & ~w_addr_ok) | (r_err[0] & ~err_clr);
      r_err[1] <= (w_copy & w_vb_fall)    | (r_err[1] & ~err_clr);
    end
  end

  // Shadow bank writes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) r_shadow[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (w_wr_acc && w_addr_ok && (32'(wr_addr) == i)) r_shadow[i] <= wr_data;
      end
    end
  end

  // Active bank: one register copied per COPY cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_active <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (w_copy && (32'(r_idx) == i)) r_active[i*DATA_W +: DATA_W] <= r_shadow[i];
      end
    end
  end

endmodule

// File: tb/tb_tt_um_emern_frame_commit.sv
// Directed self-checking bench for tt_um_emern_frame_commit.
module tb_tt_um_emern_frame_commit;

  localparam int unsigned NUM_REGS = 8;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned ADDR_W   = 4;

  logic                       clk;
  logic                       rst;
  logic                       wr_valid;
  logic                       wr_ready;
  logic [ADDR_W-1:0]          wr_addr;
  logic [DATA_W-1:0]          wr_data;
  logic                       commit_req;
  logic                       vblank;
  logic [NUM_REGS*DATA_W-1:0] active_regs;
  logic                       commit_pending;
  logic                       commit_done;
  logic [7:0]                 frame_cnt;
  logic [1:0]                 err;
  logic                       err_clr;

  int checks   = 0;
  int failures = 0;
  int done_seen = 0;
  int exp_frame = 0;

  tt_um_emern_frame_commit #(
    .NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .commit_req(commit_req), .vblank(vblank),
    .active_regs(active_regs), .commit_pending(commit_pending), .commit_done(commit_done),
    .frame_cnt(frame_cnt), .err(err), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count completion pulses, sampled mid-cycle
  always @(negedge clk) if (commit_done === 1'b1) done_seen++;

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic pulse_commit();
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; vblank = 1'b1;
    tick(); tick();
    checks++; if (active_regs !== '0) begin failures++; $display("FAIL reset_active got=%h exp=0", active_regs); end
    checks++; if (err !== 2'b00) begin failures++; $display("FAIL reset_err got=%b exp=00", err); end
    checks++; if (commit_pending !== 1'b0 || commit_done !== 1'b0) begin failures++; $display("FAIL reset_flags pend=%b done=%b exp=0/0", commit_pending, commit_done); end
    checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL reset_wr_ready got=%b exp=1", wr_ready); end
    rst = 1'b0;
    tick(); tick();
    checks++; if (frame_cnt !== 8'd0) begin failures++; $display("FAIL reset_vblank_no_edge frame=%0d exp=0", frame_cnt); end
    vblank = 1'b0;
    tick();
  endtask

  task automatic test_basic_commit();
    do_write(4'd2, 16'hABCD);
    pulse_commit();
    checks++; if (commit_pending !== 1'b1) begin failures++; $display("FAIL basic_armed pend=%b exp=1", commit_pending); end
    vblank = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 3) begin
        checks++; if (active_regs[2*DATA_W +: DATA_W] !== 16'h0000) begin failures++; $display("FAIL basic_reg2_early got=%h exp=0000", active_regs[2*DATA_W +: DATA_W]); end
      end
      if (k == 4) begin
        checks++; if (active_regs[2*DATA_W +: DATA_W] !== 16'hABCD) begin failures++; $display("FAIL basic_reg2_late got=%h exp=abcd", active_regs[2*DATA_W +: DATA_W]); end
      end
      if (k == 8) begin
        checks++; if (commit_done !== 1'b0 || commit_pending !== 1'b1) begin failures++; $display("FAIL basic_T8 done=%b pend=%b exp=0/1", commit_done, commit_pending); end
        checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL basic_ready_copy got=%b exp=0", wr_ready); end
      end
      if (k == 9) begin
        checks++; if (commit_done !== 1'b1 || commit_pending !== 1'b0) begin failures++; $display("FAIL basic_T9 done=%b pend=%b exp=1/0", commit_done, commit_pending); end
      end
      if (k == 10) begin
        checks++; if (commit_done !== 1'b0) begin failures++; $display("FAIL basic_done_width got=%b exp=0", commit_done); end
      end
    end
    exp_frame++;
    vblank = 1'b0;
    tick();
    checks++; if (active_regs !== {5'd0, 16'hABCD, 32'd0} << 0 && active_regs !== 128'h0000_0000_0000_0000_0000_ABCD_0000_0000) begin failures++; $display("FAIL basic_full got=%h", active_regs); end
    checks++; if (frame_cnt !== 8'(exp_frame)) begin failures++; $display("FAIL basic_frame got=%0d exp=%0d", frame_cnt, exp_frame); end
  endtask

  task automatic test_write_during_copy();
    int lows;
    do_write(4'd5, 16'h1234);
    pulse_commit();
    vblank = 1'b1;
    tick();
    wr_valid = 1'b1; wr_addr = 4'd5; wr_data = 16'h5555;
    lows = 0;
    for (int k = 0; k < 20 && wr_ready !== 1'b1; k++) begin
      lows++;
      tick();
    end
    tick();
    wr_valid = 1'b0;
    checks++; if (lows !== 8) begin failures++; $display("FAIL wdc_ready_low_cycles got=%0d exp=8", lows); end
    checks++; if (active_regs[5*DATA_W +: DATA_W] !== 16'h1234) begin failures++; $display("FAIL wdc_reg5 got=%h exp=1234", active_regs[5*DATA_W +: DATA_W]); end
    exp_frame++;
    vblank = 1'b0;
    tick();
  endtask

  task automatic test_commit_during_copy();
    int d0;
    d0 = done_seen;
    pulse_commit();
    vblank = 1'b1;
    tick(); tick();
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
    for (int k = 3; k < 9; k++) tick();
    checks++; if (commit_done !== 1'b1 || commit_pending !== 1'b1) begin failures++; $display("FAIL cdc_first_done done=%b pend=%b exp=1/1", commit_done, commit_pending); end
    do_write(4'd1, 16'h0B0B);
    checks++; if (active_regs[1*DATA_W +: DATA_W] !== 16'h0000) begin failures++; $display("FAIL cdc_reg1_before got=%h exp=0000", active_regs[1*DATA_W +: DATA_W]); end
    exp_frame++;
    vblank = 1'b0;
    tick(); tick();
    checks++; if (commit_pending !== 1'b1) begin failures++; $display("FAIL cdc_still_armed pend=%b exp=1", commit_pending); end
    vblank = 1'b1;
    for (int k = 1; k <= 10; k++) tick();
    exp_frame++;
    vblank = 1'b0;
    tick();
    checks++; if (done_seen - d0 !== 2) begin failures++; $display("FAIL cdc_done_count got=%0d exp=2", done_seen - d0); end
    checks++; if (active_regs[1*DATA_W +: DATA_W] !== 16'h0B0B) begin failures++; $display("FAIL cdc_reg1_after got=%h exp=0b0b", active_regs[1*DATA_W +: DATA_W]); end
    checks++; if (active_regs[5*DATA_W +: DATA_W] !== 16'h5555) begin failures++; $display("FAIL cdc_reg5_after got=%h exp=5555", active_regs[5*DATA_W +: DATA_W]); end
    checks++; if (commit_pending !== 1'b0) begin failures++; $display("FAIL cdc_idle pend=%b exp=0", commit_pending); end
  endtask

  task automatic test_bad_addr();
    do_write(4'd8, 16'hFFFF);
    checks++; if (err !== 2'b01) begin failures++; $display("FAIL bad_addr_err got=%b exp=01", err); end
    err_clr = 1'b1;
    do_write(4'd8, 16'hEEEE);
    err_clr = 1'b0;
    checks++; if (err !== 2'b01) begin failures++; $display("FAIL bad_addr_set_wins got=%b exp=01", err); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++; if (err !== 2'b00) begin failures++; $display("FAIL bad_addr_clr got=%b exp=00", err); end
    pulse_commit();
    vblank = 1'b1;
    for (int k = 1; k <= 10; k++) tick();
    exp_frame++;
    vblank = 1'b0;
    tick();
    checks++; if (active_regs[0 +: DATA_W] !== 16'h0000) begin failures++; $display("FAIL bad_addr_reg0 got=%h exp=0000", active_regs[0 +: DATA_W]); end
    checks++; if (err !== 2'b00) begin failures++; $display("FAIL bad_addr_no_tear got=%b exp=00", err); end
  endtask

  task automatic test_tear();
    logic [NUM_REGS*DATA_W-1:0] exp_v;
    exp_v = '0;
    for (int i = 0; i < 8; i++) begin
      do_write(4'(i), 16'h1000 + 16'(i));
      exp_v[i*DATA_W +: DATA_W] = 16'h1000 + 16'(i);
    end
    pulse_commit();
    vblank = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k == 4) vblank = 1'b0;
    end
    exp_frame++;
    checks++; if (commit_done !== 1'b1) begin failures++; $display("FAIL tear_done got=%b exp=1", commit_done); end
    checks++; if (err !== 2'b10) begin failures++; $display("FAIL tear_err got=%b exp=10", err); end
    checks++; if (active_regs !== exp_v) begin failures++; $display("FAIL tear_copy got=%h exp=%h", active_regs, exp_v); end
    checks++; if (frame_cnt !== 8'(exp_frame)) begin failures++; $display("FAIL tear_frame got=%0d exp=%0d", frame_cnt, exp_frame); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  task automatic test_reset_mid_copy_and_wrap();
    pulse_commit();
    vblank = 1'b1;
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    checks++; if (active_regs !== '0 || commit_pending !== 1'b0) begin failures++; $display("FAIL midcopy_reset act=%h pend=%b exp=0/0", active_regs, commit_pending); end
    checks++; if (frame_cnt !== 8'd0) begin failures++; $display("FAIL midcopy_reset_frame got=%0d exp=0", frame_cnt); end
    tick();
    rst = 1'b0;
    tick(); tick();
    checks++; if (frame_cnt !== 8'd0) begin failures++; $display("FAIL wrap_no_edge got=%0d exp=0", frame_cnt); end
    vblank = 1'b0;
    tick();
    for (int i = 0; i < 255; i++) begin
      vblank = 1'b1; tick();
      vblank = 1'b0; tick();
    end
    checks++; if (frame_cnt !== 8'd255) begin failures++; $display("FAIL wrap_255 got=%0d exp=255", frame_cnt); end
    vblank = 1'b1; tick();
    vblank = 1'b0; tick();
    checks++; if (frame_cnt !== 8'd0) begin failures++; $display("FAIL wrap_0 got=%0d exp=0", frame_cnt); end
    pulse_commit();
    vblank = 1'b1;
    for (int k = 1; k <= 10; k++) tick();
    vblank = 1'b0;
    tick();
    checks++; if (active_regs !== '0) begin failures++; $display("FAIL reset_shadow_cleared got=%h exp=0", active_regs); end
  endtask

  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    commit_req = 1'b0; vblank = 1'b1; err_clr = 1'b0;
    test_reset();
    test_basic_commit();
    test_write_during_copy();
    test_commit_during_copy();
    test_bad_addr();
    test_tear();
    test_reset_mid_copy_and_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
